bus_source_mux_reg: RTL
=======================

Name: bus_source_mux_reg

Overview:
- Parametrised, registered successor to the datapath bus source multiplexer.
- Selects one of N_SRC WIDTH-bit sources onto the internal CPU bus from either a one-hot drive-enable vector (e.g. R0out..Zlowout) or an encoded select.
- Registers the result with one-cycle latency and reports the granted source.
- Holds the last driven value when no source drives, and detects multi-driver and out-of-range selects; optional round-robin arbitration of contending drivers.

Parameters:
- WIDTH, 32, bus data width.
- N_SRC, 24, number of bus sources (2..64).
- SEL_W, $clog2(N_SRC), width of encoded select/index.
- SEL_MODE, 0, 0 = one-hot drive enables (src_req), 1 = encoded select (sel, sel_valid).
- ARB_RR, 0, multi-driver policy in SEL_MODE 0: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous active-high reset.
- src_data  in  N_SRC*WIDTH  flattened sources; source i at [i*WIDTH +: WIDTH].
- src_req  in  N_SRC  one-hot drive enables (SEL_MODE 0; ignored in mode 1).
- sel  in  SEL_W  encoded source index (SEL_MODE 1).
- sel_valid  in  1  encoded select is valid this cycle (SEL_MODE 1).
- clear_err  in  1  clears sticky error flags.
- bus_q  out  WIDTH  registered bus value.
- bus_valid  out  1  high for one cycle after a cycle in which a source was granted.
- grant_idx  out  SEL_W  index of source captured into bus_q.
- conflict  out  1  sticky: more than one src_req bit seen.
- range_err  out  1  sticky: sel_valid with sel >= N_SRC.

Behaviour:
- Reset (sync): bus_q=0, bus_valid=0, grant_idx=0, conflict=0, range_err=0, rr_ptr=0. Reset dominates all other inputs; in-flight captures are discarded.
- Latency: a source presented in cycle n appears on bus_q/grant_idx after edge n+1; bus_valid high in the same cycle.
- No driver (src_req==0, or sel_valid==0): bus_q and grant_idx hold (bus keeper); bus_valid=0.
- SEL_MODE 0, exactly one req bit i: bus_q<=src_data[i], grant_idx<=i, bus_valid<=1.
- SEL_MODE 0, >=2 bits set:
  - conflict<=1.
  - ARB_RR=0: grant lowest set index.
  - ARB_RR=1: grant first set index at or above rr_ptr, wrapping modulo N_SRC; afterwards rr_ptr<=(granted+1) mod N_SRC. rr_ptr also updates on single-driver grants; wrap N_SRC-1 -> 0.
- SEL_MODE 1, sel_valid and sel<N_SRC: capture src_data[sel], bus_valid<=1.
- SEL_MODE 1, sel_valid and sel>=N_SRC: range_err<=1, bus_q<=0, grant_idx<=sel truncated to SEL_W, bus_valid<=0.
- Sticky flags: cleared by clear_err. If clear_err and a new error occur in the same cycle, the flag is set (set wins).
- No combinational path from inputs to outputs; all outputs are registered.
- Unused upper indices (N_SRC not a power of two) never grant.

Decomposition:
- Package bus_mux_pkg holds:
  - SEL_MODE_ONEHOT=0, SEL_MODE_ENC=1.
  - ARB_FIXED=0, ARB_RR=1.
  - Function clog2_min1 (returns >=1).
- Sub-module bus_rr_arbiter (N parameter):
  - Inputs: req, ptr, rr_en.
  - Outputs: grant_idx, any_req, multi_req.
  - Purely combinational; top level owns rr_ptr and all output registers.

Test Plan:
- Reset with src_req=24'h000001, src_data[0]=32'hDEADBEEF asserted: all outputs 0 during reset. After release: bus_q=DEADBEEF, grant_idx=0, bus_valid=1 one cycle later.
- SEL_MODE 0, src_req=1<<23 with src_data[23]=32'h12345678, then src_req=0 for 3 cycles: bus_q=12345678, grant_idx=23; bus_q holds through the idle cycles with bus_valid=0.
- ARB_RR=0, src_req=24'h000A00: grant_idx=9, conflict=1. Assert clear_err with src_req=0: conflict=0 next cycle. Assert clear_err together with src_req=24'h3: conflict stays 1.
- ARB_RR=1, src_req=24'h800001 held 4 cycles: grant_idx sequence 0,23,0,23; rr_ptr wraps from 0 to 1 and from 23 to 0.
- SEL_MODE 1, N_SRC=24, sel=5 with sel_valid=1: bus_q=src_data[5]. Then sel=30: range_err=1, bus_q=0, bus_valid=0. Then sel_valid=0: bus_q holds 0.
- Parametrisation check at WIDTH=16, N_SRC=5 (SEL_W=3): one-hot src_req=5'b10000 gives grant_idx=4. Encoded sel=6 sets range_err.

Source files
------------

// File: rtl/bus_source_mux_reg_pkg.sv
// Shared constants and helpers for the registered bus source multiplexer.
package bus_mux_pkg;

  localparam int SEL_MODE_ONEHOT = 0;
  localparam int SEL_MODE_ENC    = 1;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Index width that never collapses to zero bits, even for tiny source counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_source_mux_reg_if.sv
// Bus-side signal bundle: source data/requests toward the mux, registered bus back out.
interface bus_source_mux_reg_if
  import bus_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_SRC = 24,
  parameter int SEL_W = clog2_min1(N_SRC)
);

  logic [N_SRC*WIDTH-1:0] src_data;
  logic [N_SRC-1:0]       src_req;
  logic [SEL_W-1:0]       sel;
  logic                   sel_valid;
  logic                   clear_err;
  logic [WIDTH-1:0]       bus_q;
  logic                   bus_valid;
  logic [SEL_W-1:0]       grant_idx;
  logic                   conflict;
  logic                   range_err;

  modport master (
    output src_data, src_req, sel, sel_valid, clear_err,
    input  bus_q, bus_valid, grant_idx, conflict, range_err
  );

  modport slave (
    input  src_data, src_req, sel, sel_valid, clear_err,
    output bus_q, bus_valid, grant_idx, conflict, range_err
  );

endinterface

// File: rtl/bus_source_mux_reg_arb.sv
// Combinational arbiter over one-hot drive enables: fixed lowest-index or
// round-robin starting at ptr, plus any/multi driver detection.
module bus_rr_arbiter
  import bus_mux_pkg::*;
#(
  parameter int N = 24,
  parameter int W = clog2_min1(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  logic         rr_en,
  output logic [W-1:0] grant_idx,
  output logic         any_req,
  output logic         multi_req
);

  logic [W-1:0] lo_idx;
  logic [W-1:0] hi_idx;
  logic         lo_found;
  logic         hi_found;

  // hi_* is the first request at or above ptr; lo_* doubles as the wrap-around pick.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    lo_found = 1'b0;
    hi_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !lo_found) begin
        lo_idx   = W'(i);
        lo_found = 1'b1;
      end
      if (req[i] && !hi_found && (i >= int'(ptr))) begin
        hi_idx   = W'(i);
        hi_found = 1'b1;
      end
    end
    grant_idx = (rr_en && hi_found) ? hi_idx : lo_idx;
  end

  assign any_req   = |req;
  assign multi_req = |(req & (req - 1'b1));

endmodule

// File: rtl/bus_source_mux_reg.sv
// Registered CPU bus source multiplexer: one-hot or encoded source select,
// bus keeper on idle cycles, sticky conflict/range error flags.
module bus_source_mux_reg
  import bus_mux_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int N_SRC    = 24,
  parameter int SEL_W    = clog2_min1(N_SRC),
  parameter int SEL_MODE = SEL_MODE_ONEHOT,
  parameter int ARB_RR   = ARB_FIXED
) (
  input logic                 clock,
  input logic                 reset,
  bus_source_mux_reg_if.slave bus
);

  logic [N_SRC-1:0] req;
  logic [SEL_W-1:0] arb_idx;
  logic             any_req;
  logic             multi_req;

  logic [SEL_W-1:0] cap_idx;
  logic [WIDTH-1:0] cap_data;

  logic [WIDTH-1:0] data_q,      data_d;
  logic             valid_q,     valid_d;
  logic [SEL_W-1:0] grant_q,     grant_d;
  logic             conflict_q,  conflict_d;
  logic             range_err_q, range_err_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;

  assign req = (SEL_MODE == SEL_MODE_ONEHOT) ? bus.src_req : '0;

  bus_rr_arbiter #(
    .N (N_SRC),
    .W (SEL_W)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr_q),
    .rr_en     (ARB_RR != ARB_FIXED),
    .grant_idx (arb_idx),
    .any_req   (any_req),
    .multi_req (multi_req)
  );

  // Explicit compare loop keeps out-of-range selects from indexing past src_data.
  always_comb begin
    cap_idx  = (SEL_MODE == SEL_MODE_ENC) ? bus.sel : arb_idx;
    cap_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (int'(cap_idx) == i) cap_data = bus.src_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    data_d      = data_q;
    valid_d     = 1'b0;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    conflict_d  = conflict_q  & ~bus.clear_err;
    range_err_d = range_err_q & ~bus.clear_err;
    if (SEL_MODE == SEL_MODE_ENC) begin
      if (bus.sel_valid) begin
        grant_d = bus.sel;
        if (int'(bus.sel) < N_SRC) begin
          data_d  = cap_data;
          valid_d = 1'b1;
        end else begin
          data_d      = '0;
          range_err_d = 1'b1;
        end
      end
    end else if (any_req) begin
      data_d  = cap_data;
      grant_d = arb_idx;
      valid_d = 1'b1;
      if (multi_req) conflict_d = 1'b1;
      if (ARB_RR != ARB_FIXED) begin
        rr_ptr_d = (int'(arb_idx) == N_SRC - 1) ? '0 : arb_idx + 1'b1;
      end
    end
  end

  // Output register stage
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      grant_q     <= '0;
      conflict_q  <= 1'b0;
      range_err_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      grant_q     <= grant_d;
      conflict_q  <= conflict_d;
      range_err_q <= range_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.bus_q     = data_q;
  assign bus.bus_valid = valid_q;
  assign bus.grant_idx = grant_q;
  assign bus.conflict  = conflict_q;
  assign bus.range_err = range_err_q;

endmodule
